// File: rtl/flatten_feeder.sv
// Buffers one IN_SIZE-sample frame from pool2, then streams it to the FC layer after a one-cycle fc_start.
// Collect is 1 sample/cycle; feed holds fc_valid/fc_data under fc_ready backpressure and sustains 1 beat/cycle.
module flatten_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_SIZE    = 1600,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fc_start,
  output logic                  fc_valid,
  output logic [DATA_WIDTH-1:0] fc_data,
  input  logic                  fc_ready,
  input  logic                  fc_done,
  output logic                  busy,
  output logic                  drop_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [IDX_W-1:0]     LAST    = IDX_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {COLLECT, START, FEED, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]       rd_addr;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   drop_err_q, drop_err_d;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_q [IN_SIZE];
  logic [DATA_WIDTH-1:0]  rd_dat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      frame_cnt_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      frame_cnt_q <= frame_cnt_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // rd_addr looks one beat ahead on a handshake, so rd_dat_q always holds the sample at rd_idx_q.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q] <= in_data;
    end
    rd_dat_q <= mem_q[rd_addr];
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rd_addr     = rd_idx_q;
    frame_cnt_d = frame_cnt_q;
    mem_we      = 1'b0;
    in_ready    = 1'b0;
    fc_start    = 1'b0;
    fc_valid    = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_idx_d = '0;
            state_d  = START;
          end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
          end
        end
      end
      START: begin
        fc_start = 1'b1;
        state_d  = FEED;
      end
      FEED: begin
        fc_valid = 1'b1;
        if (fc_ready) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d = '0;
            rd_addr  = '0;
            state_d  = WAIT;
          end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
            rd_addr  = rd_idx_q + IDX_ONE;
          end
        end
      end
      WAIT: begin
        if (fc_done) begin
          frame_cnt_d = frame_cnt_q + CNT_ONE;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    drop_err_d = drop_err_q | (in_valid & ~in_ready);
  end

  assign fc_data   = fc_valid ? rd_dat_q : '0;
  assign busy      = (state_q != COLLECT);
  assign drop_err  = drop_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
